sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 135 +++++++++++++
 tb/tb_sram_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single-request handshake on the user side and
// a registered CEn/WEn/OEn/BEn/A/D pin interface on the SRAM side. Reads go
// IDLE -> RD -> TURN, writes go IDLE -> WSETUP -> WPULSE -> WHOLD, and every
// pin and status output comes straight from a flop.
module sram_ctrl #(
   parameter int unsigned AW          = 19,
   parameter int unsigned DW          = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [AW-1:0]     address,
   input  logic [DW-1:0]     dataw,
   input  logic [DW/8-1:0]   be,
   output logic              ready,
   output logic [DW-1:0]     datar,
   output logic              rvalid,
   output logic              wdone,
   output logic [AW-1:0]     A,
   inout  wire  [DW-1:0]     D,
   output logic              CEn,
   output logic              WEn,
   output logic              OEn,
   output logic [DW/8-1:0]   BEn
);

   localparam int unsigned NB      = DW / 8;
   localparam logic [3:0]  CntLoad = 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StTurn,
      StWsetup,
      StWpulse,
      StWhold
   } state_e;

   state_e          state_q;
   logic [3:0]      cnt_q;
   logic            d_oe_q;
   logic [DW-1:0]   d_out_q;

   // The data bus is only driven from registered enable/data.
   assign D = d_oe_q ? d_out_q : {DW{1'bz}};

   // Access sequencer: state, wait counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         ready   <= 1'b0;
         rvalid  <= 1'b0;
         wdone   <= 1'b0;
         datar   <= '0;
         A       <= '0;
         CEn     <= 1'b1;
         WEn     <= 1'b1;
         OEn     <= 1'b1;
         BEn     <= {NB{1'b1}};
         d_oe_q  <= 1'b0;
         d_out_q <= '0;
      end else begin
         // Status strobes are single-cycle unless re-asserted below.
         rvalid <= 1'b0;
         wdone  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req && ready) begin
                  ready <= 1'b0;
                  A     <= address;
                  BEn   <= ~be;
                  CEn   <= 1'b0;
                  if (we) begin
                     d_out_q <= dataw;
                     d_oe_q  <= 1'b1;
                     state_q <= StWsetup;
                  end else begin
                     OEn     <= 1'b0;
                     cnt_q   <= CntLoad;
                     state_q <= StRd;
                  end
               end else begin
                  ready <= 1'b1;
               end
            end
            StRd: begin
               if (cnt_q == 4'd0) begin
                  // Sample the bus while OEn is still low, then release it.
                  datar   <= D;
                  rvalid  <= 1'b1;
                  CEn     <= 1'b1;
                  OEn     <= 1'b1;
                  BEn     <= {NB{1'b1}};
                  state_q <= StTurn;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StTurn: begin
               // One dead cycle so a following write never meets a driving SRAM.
               ready   <= 1'b1;
               state_q <= StIdle;
            end
            StWsetup: begin
               WEn     <= 1'b0;
               cnt_q   <= CntLoad;
               state_q <= StWpulse;
            end
            StWpulse: begin
               if (cnt_q == 4'd0) begin
                  WEn     <= 1'b1;
                  wdone   <= 1'b1;
                  state_q <= StWhold;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StWhold: begin
               CEn     <= 1'b1;
               BEn     <= {NB{1'b1}};
               d_oe_q  <= 1'b0;
               ready   <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (WAIT_CYCLES 2/16-bit,
// 1/32-bit, 15/32-bit), each with a behavioural asynchronous SRAM on its pins.
module tb_sram_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int          sel;
   logic        g_req;
   logic        g_we;
   logic [18:0] g_addr;
   logic [31:0] g_dw;
   logic [3:0]  g_be;

   // Instance 0: WAIT_CYCLES=2, DW=16
   logic        ready0, rvalid0, wdone0, cen0, wen0, oen0;
   logic [15:0] datar0;
   logic [18:0] a0;
   logic [1:0]  ben0;
   wire  [15:0] d0;
   // Instance 1: WAIT_CYCLES=1, DW=32
   logic        ready1, rvalid1, wdone1, cen1, wen1, oen1;
   logic [31:0] datar1;
   logic [7:0]  a1;
   logic [3:0]  ben1;
   wire  [31:0] d1;
   // Instance 2: WAIT_CYCLES=15, DW=32
   logic        ready2, rvalid2, wdone2, cen2, wen2, oen2;
   logic [31:0] datar2;
   logic [7:0]  a2;
   logic [3:0]  ben2;
   wire  [31:0] d2;

   sram_ctrl #(.AW(19), .DW(16), .WAIT_CYCLES(2)) u_main (
      .clk(clk), .rst(rst), .req(g_req && (sel == 0)), .we(g_we), .address(g_addr),
      .dataw(g_dw[15:0]), .be(g_be[1:0]), .ready(ready0), .datar(datar0), .rvalid(rvalid0),
      .wdone(wdone0), .A(a0), .D(d0), .CEn(cen0), .WEn(wen0), .OEn(oen0), .BEn(ben0)
   );

   sram_ctrl #(.AW(8), .DW(32), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst), .req(g_req && (sel == 1)), .we(g_we), .address(g_addr[7:0]),
      .dataw(g_dw), .be(g_be), .ready(ready1), .datar(datar1), .rvalid(rvalid1),
      .wdone(wdone1), .A(a1), .D(d1), .CEn(cen1), .WEn(wen1), .OEn(oen1), .BEn(ben1)
   );

   sram_ctrl #(.AW(8), .DW(32), .WAIT_CYCLES(15)) u_w15 (
      .clk(clk), .rst(rst), .req(g_req && (sel == 2)), .we(g_we), .address(g_addr[7:0]),
      .dataw(g_dw), .be(g_be), .ready(ready2), .datar(datar2), .rvalid(rvalid2),
      .wdone(wdone2), .A(a2), .D(d2), .CEn(cen2), .WEn(wen2), .OEn(oen2), .BEn(ben2)
   );

   // Behavioural SRAMs: drive D while CEn and OEn are low, write enabled lanes while WEn is low.
   logic [15:0] mem0 [256];
   logic [31:0] mem1 [256];
   logic [31:0] mem2 [256];

   assign d0 = (!cen0 && !oen0) ? mem0[a0[7:0]] : 'z;
   assign d1 = (!cen1 && !oen1) ? mem1[a1] : 'z;
   assign d2 = (!cen2 && !oen2) ? mem2[a2] : 'z;

   always @(posedge clk) begin
      if (!cen0 && !wen0)
         for (int b = 0; b < 2; b++)
            if (!ben0[b]) mem0[a0[7:0]][8*b +: 8] <= d0[8*b +: 8];
      if (!cen1 && !wen1)
         for (int b = 0; b < 4; b++)
            if (!ben1[b]) mem1[a1][8*b +: 8] <= d1[8*b +: 8];
      if (!cen2 && !wen2)
         for (int b = 0; b < 4; b++)
            if (!ben2[b]) mem2[a2][8*b +: 8] <= d2[8*b +: 8];
   end

   // Observation view of the selected instance, widened to 32-bit data / 19-bit address.
   logic        m_ready, m_rvalid, m_wdone, m_cen, m_wen, m_oen, m_doe;
   logic [31:0] m_datar, m_d;
   logic [18:0] m_a;
   logic [3:0]  m_ben;

   always_comb begin
      m_ready = ready0; m_rvalid = rvalid0; m_wdone = wdone0;
      m_cen = cen0; m_wen = wen0; m_oen = oen0; m_doe = u_main.d_oe_q;
      m_datar = {16'h0, datar0}; m_d = {16'h0, d0}; m_a = a0; m_ben = {2'b11, ben0};
      if (sel == 1) begin
         m_ready = ready1; m_rvalid = rvalid1; m_wdone = wdone1;
         m_cen = cen1; m_wen = wen1; m_oen = oen1; m_doe = u_w1.d_oe_q;
         m_datar = datar1; m_d = d1; m_a = {11'h0, a1}; m_ben = ben1;
      end else if (sel == 2) begin
         m_ready = ready2; m_rvalid = rvalid2; m_wdone = wdone2;
         m_cen = cen2; m_wen = wen2; m_oen = oen2; m_doe = u_w15.d_oe_q;
         m_datar = datar2; m_d = d2; m_a = {11'h0, a2}; m_ben = ben2;
      end
   end

   typedef struct {
      int          rv_cyc, rv_cnt, wd_cyc, wd_cnt, wlow, wlow_first, olow, act, rdy_cyc;
      int          hold_err, d_err;
      logic [31:0] rdata;
   } meas_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int wsel(input int s);
      if (s == 0) return 2;
      if (s == 1) return 1;
      return 15;
   endfunction

   // Contention watch: OEn low must never coincide with the controller driving D.
   always @(negedge clk) begin
      if (!rst && !m_oen) chk("bus_contention", {31'h0, m_doe}, 32'h0);
   end

   task automatic wait_ready();
      for (int n = 0; n < 50 && !m_ready; n++) @(negedge clk);
   endtask

   // Issue one request on the selected instance and record what the pins do per cycle.
   // Cycle 1 is the cycle that starts at the accept edge.
   task automatic access(input logic w, input logic [18:0] ad, input logic [31:0] dt,
                         input logic [3:0] b, output meas_t m);
      m = '{default: 0};
      m.rv_cyc = -1; m.wd_cyc = -1; m.wlow_first = -1; m.rdy_cyc = -1;
      wait_ready();
      g_req = 1'b1; g_we = w; g_addr = ad; g_dw = dt; g_be = b;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) g_req = 1'b0;
         if (m_rvalid) begin
            m.rv_cnt++;
            if (m.rv_cyc < 0) m.rv_cyc = c;
         end
         if (m_wdone) begin
            m.wd_cnt++;
            if (m.wd_cyc < 0) m.wd_cyc = c;
         end
         if (!m_wen) begin
            m.wlow++;
            if (m.wlow_first < 0) m.wlow_first = c;
         end
         if (!m_oen) m.olow++;
         if (!m_cen) begin
            m.act++;
            if (m_a !== ad || m_ben !== ~b) m.hold_err++;
            if (w && (m_doe !== 1'b1 || m_d !== dt)) m.d_err++;
            if (!w && m_doe !== 1'b0) m.d_err++;
         end
         if (m_ready) begin
            m.rdy_cyc = c;
            if (m_cen !== 1'b1 || m_wen !== 1'b1 || m_oen !== 1'b1 || m_ben !== 4'hF ||
                m_doe !== 1'b0 || m_a !== ad) m.hold_err++;
            break;
         end
      end
      m.rdata = m_datar;
   endtask

   task automatic do_write(input string tag, input logic [18:0] ad, input logic [31:0] dt,
                           input logic [3:0] b);
      meas_t m;
      int    w;
      w = wsel(sel);
      access(1'b1, ad, dt, b, m);
      chk({tag, "_wdone_cycle"}, m.wd_cyc, w + 2);
      chk({tag, "_wdone_count"}, m.wd_cnt, 1);
      chk({tag, "_wen_low_cycles"}, m.wlow, w);
      chk({tag, "_wen_first_low"}, m.wlow_first, 2);
      chk({tag, "_cen_low_cycles"}, m.act, w + 2);
      chk({tag, "_ready_cycle"}, m.rdy_cyc, w + 3);
      chk({tag, "_no_rvalid"}, m.rv_cnt, 0);
      chk({tag, "_a_ben_idle"}, m.hold_err, 0);
      chk({tag, "_d_drive"}, m.d_err, 0);
   endtask

   task automatic do_read(input string tag, input logic [18:0] ad, input logic [3:0] b,
                          input logic [31:0] exp);
      meas_t m;
      int    w;
      w = wsel(sel);
      access(1'b0, ad, 32'h0, b, m);
      chk({tag, "_rvalid_cycle"}, m.rv_cyc, w + 1);
      chk({tag, "_rvalid_count"}, m.rv_cnt, 1);
      chk({tag, "_oen_low_cycles"}, m.olow, w);
      chk({tag, "_cen_low_cycles"}, m.act, w);
      chk({tag, "_ready_cycle"}, m.rdy_cyc, w + 2);
      chk({tag, "_no_wdone"}, m.wd_cnt, 0);
      chk({tag, "_a_ben_idle"}, m.hold_err, 0);
      chk({tag, "_d_released"}, m.d_err, 0);
      chk({tag, "_datar"}, m.rdata, exp);
   endtask

   initial begin
      int last_rd, ws, gap, wd_seen;
      rst = 1'b1; sel = 0; g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_dw = '0; g_be = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ready", {31'h0, ready0}, 32'h0);
      chk("rst_rvalid", {31'h0, rvalid0}, 32'h0);
      chk("rst_wdone", {31'h0, wdone0}, 32'h0);
      chk("rst_ctl", {29'h0, cen0, wen0, oen0}, 32'h7);
      chk("rst_ben", {30'h0, ben0}, 32'h3);
      chk("rst_a", {13'h0, a0}, 32'h0);
      chk("rst_datar", {16'h0, datar0}, 32'h0);
      chk("rst_d_released", {31'h0, u_main.d_oe_q}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", {31'h0, ready0}, 32'h1);

      // Basic write / readback, then a partial-lane write over a known word
      do_write("wr_1a2b", 19'h00055, 32'h1A2B, 4'b0011);
      do_read("rd_1a2b", 19'h00055, 4'b0011, 32'h1A2B);
      do_write("wr_aaaa", 19'h00056, 32'hAAAA, 4'b0011);
      do_write("wr_lane0", 19'h00056, 32'h00FF, 4'b0001);
      do_read("rd_lane0", 19'h00056, 4'b0011, 32'hAAFF);

      // Read then write with req held high: spacing and bus turnaround
      wait_ready();
      g_req = 1'b1; g_we = 1'b0; g_addr = 19'h00055; g_be = 4'b0011; g_dw = 32'h0;
      @(negedge clk);
      g_we = 1'b1; g_addr = 19'h00057; g_dw = 32'h1234;
      last_rd = -1; ws = -1; gap = 0; wd_seen = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) @(negedge clk);
         if (!m_oen) last_rd = c;
         if (ws < 0 && !m_cen && m_wen && m_doe) begin
            ws = c;
            g_req = 1'b0;
         end
         if (ws < 0 && last_rd > 0 && m_oen && !m_doe) gap++;
         if (m_wdone) wd_seen++;
      end
      chk("turn_last_rd_cycle", last_rd, 2);
      chk("turn_wsetup_cycle", ws, 5);
      chk("turn_gap_present", {31'h0, gap >= 1}, 32'h1);
      chk("turn_wdone_count", wd_seen, 1);
      do_read("rd_turn", 19'h00057, 4'b0011, 32'h1234);

      // Reset during WPULSE aborts the write
      wait_ready();
      g_req = 1'b1; g_we = 1'b1; g_addr = 19'h00058; g_dw = 32'hBEEF; g_be = 4'b0011;
      @(negedge clk);
      g_req = 1'b0;
      @(negedge clk);
      chk("abort_in_wpulse", {31'h0, wen0}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_wen", {31'h0, wen0}, 32'h1);
      chk("abort_cen", {31'h0, cen0}, 32'h1);
      chk("abort_d_released", {31'h0, u_main.d_oe_q}, 32'h0);
      chk("abort_wdone", {31'h0, wdone0}, 32'h0);
      chk("abort_ready", {31'h0, ready0}, 32'h0);
      chk("abort_a", {13'h0, a0}, 32'h0);
      chk("abort_datar", {16'h0, datar0}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", {31'h0, ready0}, 32'h1);
      chk("abort_wdone_after", {31'h0, wdone0}, 32'h0);

      // Parameter sweep: WAIT_CYCLES 1 and 15 with four byte lanes
      for (int s = 1; s <= 2; s++) begin
         sel = s;
         @(negedge clk);
         do_write("sw_full", 19'h3, 32'h11223344, 4'b1111);
         do_write("sw_lanes02", 19'h3, 32'hAABBCCDD, 4'b0101);
         do_write("sw_lanes13", 19'h3, 32'h55667788, 4'b1010);
         do_read("sw_rd_mix", 19'h3, 4'b1111, 32'h55BB77DD);
         do_write("sw_no_lanes", 19'h3, 32'hFFFFFFFF, 4'b0000);
         do_read("sw_rd_keep", 19'h3, 4'b0110, 32'h55BB77DD);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
